// File: rtl/wired_lsu_sb_queue.sv
// Circular store-buffer queue: speculative store allocation with snoop bypass,
// in-order commit tracking, one-store-per-cycle drain and refill requests on a missing head.

package wired_lsu_sb_pkg;

   typedef struct packed {
      logic [31:0] paddr;
      logic [3:0]  hit;
      logic [31:0] data;
      logic [3:0]  strobe;
   } sb_meta_t;

   typedef struct packed {
      logic [19:0] p;
      logic        wp;
   } dsram_tag_t;

   typedef struct packed {
      logic [11:4] taddr;
      logic [3:0]  twe;
      dsram_tag_t  t;
   } dsram_snoop_t;

   // A tag write to the entry's set rewrites the hit bit of every written way.
   function automatic sb_meta_t snoop_apply(input sb_meta_t m, input dsram_snoop_t s);
      sb_meta_t r;
      r = m;
      if (m.paddr[11:4] == s.taddr) begin
         for (int w = 0; w < 4; w++) begin
            if (s.twe[w]) r.hit[w] = (s.t.p == m.paddr[31:12]) && s.t.wp;
         end
      end
      return r;
   endfunction

endpackage

module wired_lsu_sb_queue
   import wired_lsu_sb_pkg::*;
#(
   parameter int SB_DEPTH = 4,
   parameter int PTR_W    = $clog2(SB_DEPTH)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push_valid_i,
   output logic                        push_ready_o,
   input  sb_meta_t                    push_meta_i,
   input  logic                        commit_i,
   input  logic                        flush_i,
   input  dsram_snoop_t                snoop_i,
   output logic                        drain_valid_o,
   input  logic                        drain_ready_i,
   output sb_meta_t                    drain_meta_o,
   output logic [1:0]                  drain_way_o,
   output logic                        miss_valid_o,
   input  logic                        miss_ready_i,
   output logic [31:0]                 miss_paddr_o,
   output logic [SB_DEPTH-1:0]         entry_valid_o,
   output sb_meta_t [SB_DEPTH-1:0]     entry_meta_o,
   output logic                        empty_o,
   output logic                        full_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MISS_REQ,
      S_MISS_WAIT
   } state_e;

   typedef logic [PTR_W:0] ptr_t;

   ptr_t                head_q, head_d;
   ptr_t                cptr_q, cptr_d;
   ptr_t                tail_q, tail_d;
   ptr_t                unc_cnt;
   logic [SB_DEPTH-1:0] valid_q, valid_d;
   sb_meta_t            meta_q [SB_DEPTH];
   sb_meta_t            meta_d [SB_DEPTH];
   state_e              state_q, state_d;

   logic [PTR_W-1:0] head_idx, tail_idx;
   sb_meta_t         head_meta;
   logic             eligible, conflict;
   logic             push_fire, pop_fire, commit_fire;

   assign head_idx = head_q[PTR_W-1:0];
   assign tail_idx = tail_q[PTR_W-1:0];

   assign full_o       = (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]) && (head_q[PTR_W] != tail_q[PTR_W]);
   assign empty_o      = (head_q == tail_q);
   assign push_ready_o = !full_o && !flush_i;

   assign push_fire   = push_valid_i && push_ready_o;
   assign commit_fire = commit_i && (cptr_q != tail_q);
   assign pop_fire    = drain_valid_o && drain_ready_i;

   assign head_meta = valid_q[head_idx] ? meta_q[head_idx] : '0;
   assign eligible  = (head_q != cptr_q);
   // A tag write to the head's set this cycle makes its registered hit stale.
   assign conflict  = (snoop_i.twe != 4'b0) && (snoop_i.taddr == head_meta.paddr[11:4]);

   assign drain_meta_o  = head_meta;
   assign miss_paddr_o  = {head_meta.paddr[31:4], 4'b0000};
   assign entry_valid_o = valid_q;

   always_comb begin
      for (int i = 0; i < SB_DEPTH; i++) begin
         entry_meta_o[i] = valid_q[i] ? meta_q[i] : '0;
      end
   end

   always_comb begin
      drain_way_o = 2'd0;
      for (int w = 3; w >= 0; w--) begin
         if (head_meta.hit[w]) drain_way_o = 2'(w);
      end
   end

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case statement can leave a latch behind.
   always_comb begin
      state_d       = state_q;
      drain_valid_o = 1'b0;
      miss_valid_o  = 1'b0;
      case (state_q)
         S_IDLE: begin
            drain_valid_o = eligible && (head_meta.hit != 4'b0) && !conflict;
            if (eligible && (head_meta.hit == 4'b0) && !conflict) state_d = S_MISS_REQ;
         end
         S_MISS_REQ: begin
            miss_valid_o = 1'b1;
            if (miss_ready_i) state_d = S_MISS_WAIT;
         end
         S_MISS_WAIT: begin
            if (head_meta.hit != 4'b0) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      head_d  = head_q + ptr_t'(pop_fire);
      cptr_d  = cptr_q + ptr_t'(commit_fire);
      tail_d  = tail_q + ptr_t'(push_fire);
      valid_d = valid_q;
      for (int i = 0; i < SB_DEPTH; i++) begin
         meta_d[i] = valid_q[i] ? snoop_apply(meta_q[i], snoop_i) : meta_q[i];
      end

      if (pop_fire) valid_d[head_idx] = 1'b0;

      // The commit of this cycle is honoured before the uncommitted tail is cut.
      unc_cnt = tail_q - cptr_d;
      if (flush_i) begin
         tail_d = cptr_d;
         for (int i = 0; i < SB_DEPTH; i++) begin
            if (ptr_t'(PTR_W'(i) - cptr_d[PTR_W-1:0]) < unc_cnt) valid_d[i] = 1'b0;
         end
      end

      if (push_fire) begin
         valid_d[tail_idx] = 1'b1;
         meta_d[tail_idx]  = snoop_apply(push_meta_i, snoop_i);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         cptr_q  <= '0;
         tail_q  <= '0;
         valid_q <= '0;
         state_q <= S_IDLE;
      end else begin
         head_q  <= head_d;
         cptr_q  <= cptr_d;
         tail_q  <= tail_d;
         valid_q <= valid_d;
         state_q <= state_d;
      end
   end

   // NOTE: entry payloads are not reset; valid_q qualifies them and every
   // visible copy is forced to zero while its entry is invalid.
   always_ff @(posedge clk) begin
      meta_q <= meta_d;
   end

   a_commit_has_entry: assert property (@(posedge clk) disable iff (rst)
      commit_i |-> (cptr_q != tail_q));

endmodule

// File: tb/tb_wired_lsu_sb_queue.sv
// Randomized bench for wired_lsu_sb_queue against a queue-based reference model.
module tb_wired_lsu_sb_queue;
   import wired_lsu_sb_pkg::*;

   localparam int D = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             push_valid_i, push_ready_o;
   sb_meta_t         push_meta_i;
   logic             commit_i, flush_i;
   dsram_snoop_t     snoop_i;
   logic             drain_valid_o, drain_ready_i;
   sb_meta_t         drain_meta_o;
   logic [1:0]       drain_way_o;
   logic             miss_valid_o, miss_ready_i;
   logic [31:0]      miss_paddr_o;
   logic [D-1:0]     entry_valid_o;
   sb_meta_t [D-1:0] entry_meta_o;
   logic             empty_o, full_o;

   always #5 clk = ~clk;

   wired_lsu_sb_queue #(.SB_DEPTH(D)) dut (
      .clk(clk), .rst(rst),
      .push_valid_i(push_valid_i), .push_ready_o(push_ready_o), .push_meta_i(push_meta_i),
      .commit_i(commit_i), .flush_i(flush_i), .snoop_i(snoop_i),
      .drain_valid_o(drain_valid_o), .drain_ready_i(drain_ready_i),
      .drain_meta_o(drain_meta_o), .drain_way_o(drain_way_o),
      .miss_valid_o(miss_valid_o), .miss_ready_i(miss_ready_i), .miss_paddr_o(miss_paddr_o),
      .entry_valid_o(entry_valid_o), .entry_meta_o(entry_meta_o),
      .empty_o(empty_o), .full_o(full_o)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: oldest store at mq[0], first ncom of them committed.
   sb_meta_t mq[$];
   int       ncom, mhead;
   bit       m_req, m_wait;

   function automatic sb_meta_t m_snoop(input sb_meta_t m, input dsram_snoop_t s);
      sb_meta_t r = m;
      if (m.paddr[11:4] == s.taddr[11:4])
         for (int w = 0; w < 4; w++)
            if (s.twe[w]) r.hit[w] = (m.paddr[31:12] == s.t.p) && s.t.wp;
      return r;
   endfunction

   task automatic model_reset();
      mq.delete();
      ncom = 0; mhead = 0; m_req = 0; m_wait = 0;
   endtask

   task automatic clr_inputs();
      push_valid_i = 0; push_meta_i = '0; commit_i = 0; flush_i = 0;
      snoop_i = '0; drain_ready_i = 0; miss_ready_i = 0;
   endtask

   // Called at the falling edge with inputs already driven.
   task automatic cycle();
      int        sz;
      sb_meta_t  h;
      bit        elig, conf, idle, e_dv, e_full, e_pr, pop, pushf, comf, go_req, req_done, wait_done;
      int        e_way;
      bit        exp_v [D];
      sb_meta_t  exp_m [D];
      #1;
      sz   = mq.size();
      h    = (sz > 0) ? mq[0] : '0;
      elig = ncom > 0;
      conf = (snoop_i.twe != 0) && (snoop_i.taddr[11:4] == h.paddr[11:4]);
      idle = !m_req && !m_wait;
      e_dv = idle && elig && (h.hit != 0) && !conf;
      e_way = 0;
      for (int w = 3; w >= 0; w--) if (h.hit[w]) e_way = w;
      e_full = (sz == D);
      e_pr   = !e_full && !flush_i;
      for (int i = 0; i < D; i++) begin exp_v[i] = 0; exp_m[i] = '0; end
      for (int k = 0; k < sz; k++) begin
         exp_v[(mhead + k) % D] = 1;
         exp_m[(mhead + k) % D] = mq[k];
      end
      if (!rst) begin
         check("push_ready", push_ready_o, e_pr);
         check("full", full_o, e_full);
         check("empty", empty_o, sz == 0);
         check("drain_valid", drain_valid_o, e_dv);
         if (e_dv) check("drain_way", drain_way_o, e_way);
         check("drain_meta", drain_meta_o, h);
         check("miss_valid", miss_valid_o, m_req);
         if (m_req) check("miss_paddr", miss_paddr_o, {h.paddr[31:4], 4'h0});
         for (int i = 0; i < D; i++) begin
            check($sformatf("entry_valid%0d", i), entry_valid_o[i], exp_v[i]);
            check($sformatf("entry_meta%0d", i), entry_meta_o[i], exp_m[i]);
         end
      end
      pop       = e_dv && drain_ready_i;
      pushf     = push_valid_i && e_pr;
      comf      = commit_i && (ncom < sz);
      go_req    = idle && elig && (h.hit == 0) && !conf;
      req_done  = m_req && miss_ready_i;
      wait_done = m_wait && (h.hit != 0);
      @(posedge clk);
      if (rst) model_reset();
      else begin
         foreach (mq[k]) mq[k] = m_snoop(mq[k], snoop_i);
         if (pop) begin void'(mq.pop_front()); ncom--; mhead = (mhead + 1) % D; end
         if (comf) ncom++;
         if (flush_i) while (mq.size() > ncom) void'(mq.pop_back());
         if (pushf) mq.push_back(m_snoop(push_meta_i, snoop_i));
         if (go_req) m_req = 1;
         if (req_done) begin m_req = 0; m_wait = 1; end
         if (wait_done) m_wait = 0;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      clr_inputs();
      rst = 1;
      cycle(); cycle();
      rst = 0;
      #1;
      check("rst_push_ready", push_ready_o, 1'b1);
      check("rst_empty", empty_o, 1'b1);
      check("rst_full", full_o, 1'b0);
      check("rst_drain_valid", drain_valid_o, 1'b0);
      check("rst_drain_way", drain_way_o, 2'd0);
      check("rst_miss_valid", miss_valid_o, 1'b0);
      check("rst_miss_paddr", miss_paddr_o, 32'h0);
      check("rst_entry_valid", entry_valid_o, '0);
      check("rst_entry_meta", entry_meta_o, '0);
      #1;
      @(negedge clk);
   endtask

   task automatic set_push(input logic [31:0] pa, input logic [3:0] hit);
      push_valid_i = 1;
      push_meta_i  = '{paddr: pa, hit: hit, data: $urandom, strobe: 4'($urandom)};
   endtask

   task automatic set_snoop(input logic [7:0] set, input logic [3:0] twe, input logic [19:0] p, input logic wp);
      snoop_i = '{taddr: set, twe: twe, t: '{p: p, wp: wp}};
   endtask

   task automatic rand_inputs();
      push_valid_i = $urandom_range(0, 1);
      push_meta_i  = '{paddr: {20'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 4'($urandom)},
                       hit: ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom),
                       data: $urandom, strobe: 4'($urandom)};
      commit_i      = (ncom < mq.size()) && ($urandom_range(0, 2) == 0);
      flush_i       = ($urandom_range(0, 15) == 0);
      set_snoop(8'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
                20'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
      drain_ready_i = $urandom_range(0, 1);
      miss_ready_i  = $urandom_range(0, 1);
   endtask

   initial begin
      rst = 1;
      clr_inputs();
      model_reset();
      @(negedge clk);
      do_reset();

      // Fill with four hit-in-way-1 stores, then try a fifth.
      for (int i = 0; i < 4; i++) begin
         clr_inputs(); set_push(32'h1000 + 32'(i) * 32'h10, 4'b0010); cycle();
      end
      clr_inputs(); set_push(32'h1050, 4'b0010); cycle();
      check("full_after_fill", full_o, 1'b1);

      // Commit two with the write port always ready; the rest must stay put.
      clr_inputs(); drain_ready_i = 1; commit_i = 1; cycle(); cycle();
      commit_i = 0; cycle(); cycle(); cycle();
      check("two_left", mq.size(), 2);

      // Drop the uncommitted pair, then a missing store and its refill.
      clr_inputs(); flush_i = 1; cycle();
      clr_inputs(); set_push(32'h2040, 4'b0000); cycle();
      clr_inputs(); commit_i = 1; cycle();
      clr_inputs(); cycle(); cycle(); cycle();
      check("miss_held", miss_valid_o, 1'b1);
      miss_ready_i = 1; cycle();
      clr_inputs(); cycle();
      set_snoop(8'h04, 4'b1000, 20'h2, 1'b1); cycle();
      clr_inputs(); drain_ready_i = 1; cycle(); cycle(); cycle();

      // Push racing a snoop that clears way 1, then flush it away.
      clr_inputs(); set_push(32'h3050, 4'b0010); set_snoop(8'h05, 4'b0010, 20'h3, 1'b0); cycle();
      clr_inputs(); flush_i = 1; cycle();

      // Committed head with a same-cycle snoop to its set.
      clr_inputs(); set_push(32'h4060, 4'b0001); cycle();
      clr_inputs(); commit_i = 1; cycle();
      clr_inputs(); drain_ready_i = 1; set_snoop(8'h06, 4'b0001, 20'h4, 1'b1); cycle();
      clr_inputs(); drain_ready_i = 1; cycle(); cycle();

      // Two committed, two uncommitted, flush with a concurrent push.
      for (int i = 0; i < 4; i++) begin
         clr_inputs(); set_push(32'h5000 + 32'(i) * 32'h10, 4'b0100); cycle();
      end
      clr_inputs(); commit_i = 1; cycle(); cycle();
      clr_inputs(); flush_i = 1; set_push(32'h5100, 4'b0100); cycle();
      clr_inputs(); cycle();
      check("flush_kept", mq.size(), 2);

      do_reset();
      for (int n = 0; n < 3000; n++) begin
         rand_inputs();
         if (n == 1500) do_reset();
         else cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wired_lsu_sb_queue.md
Name: wired_lsu_sb_queue

Overview:
Circular store-buffer queue controller for the LSU. It allocates entries for speculative stores and applies same-cycle SRAM snoop bypass when writing them. It tracks each entry's commit state and drains committed stores in order to the dcache SRAM write port. When the oldest committed store has no writable way, it issues a refill request.

Parameters:
SB_DEPTH, 4, number of entries; power of two, at least 2.
PTR_W, $clog2(SB_DEPTH), index width; each pointer carries one extra wrap bit.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
push_valid_i  in  1  new speculative store
push_ready_o  out  1  queue not full and flush_i low
push_meta_i  in  sb_meta_t  store meta (paddr, hit[3:0], data, strobe)
commit_i  in  1  oldest uncommitted entry becomes committed
flush_i  in  1  discard all uncommitted entries
snoop_i  in  dsram_snoop_t  tag-SRAM write snoop (taddr, twe[3:0], t.p, t.wp)
drain_valid_o  out  1  head store ready to write SRAM
drain_ready_i  in  1  SRAM write accepted
drain_meta_o  out  sb_meta_t  head entry meta
drain_way_o  out  2  way to write
miss_valid_o  out  1  refill request for head paddr
miss_ready_i  in  1  refill request accepted
miss_paddr_o  out  32  head paddr, bits [3:0] zeroed
entry_valid_o  out  SB_DEPTH  per-entry valid, for load forwarding
entry_meta_o  out  SB_DEPTH x sb_meta_t  per-entry meta, snoop-updated
empty_o  out  1  no valid entries
full_o  out  1  all entries valid

Behaviour:
- Reset: head, commit_ptr and tail are 0; all valids are 0; FSM is IDLE; every output is 0 except push_ready_o=1 and empty_o=1.
- Pointers are PTR_W+1 bits.
  - full: index bits equal, wrap bits differ.
  - empty: head==tail.
  - Committed region is [head, commit_ptr); uncommitted region is [commit_ptr, tail).
- Push: accepted when push_valid_i && push_ready_o.
  - Writes entry[tail] and sets its valid; tail advances next cycle.
  - The stored meta is push_meta_i with the same-cycle snoop applied.
- Snoop update applies to every valid entry every cycle.
  - Condition: paddr[11:4]==taddr[11:4].
  - For each w with twe[w] set: hit[w] <= (t.p==paddr[31:12]) && t.wp.
  - Ways without twe set are unchanged.
- Commit: increments commit_ptr when commit_ptr!=tail.
  - commit_i with no uncommitted entry is ignored and flagged by an assertion.
  - Only entries pushed in a prior cycle can be committed.
- Flush: tail <= commit_ptr and the valids of the uncommitted entries clear next cycle.
  - Committed entries are kept.
  - commit_i in the flush cycle is applied first; the newly committed entry survives.
  - A push in the flush cycle is refused.
- Drain FSM states:
  - IDLE:
    - Head eligible when head!=commit_ptr.
    - drain_valid_o = eligible && |hit && no snoop conflict on head this cycle. Conflict: twe!=0 && taddr[11:4]==head paddr[11:4].
    - drain_way_o = lowest set hit bit.
    - Handshake pops the head: valid clears and head increments next cycle. The FSM stays in IDLE, giving one store per cycle at most.
    - If eligible && hit==0 && no conflict, go to MISS_REQ.
  - MISS_REQ: miss_valid_o=1 and held stable until miss_ready_i; then go to MISS_WAIT.
  - MISS_WAIT: wait until the head's registered hit!=0, then return to IDLE. No timeout.
- Pop and push in the same cycle are both honoured when not full. push_ready_o uses registered full, so a full queue refuses a push even in a pop cycle.
- drain_meta_o, entry_meta_o, miss_paddr_o: contents are registered (snoop-updated) entry state; zero when the corresponding entry is invalid.
- empty_o and full_o are combinational from registered pointers.
- Reset mid-operation drops all entries and any outstanding miss handshake.

Test Plan:
- Reset, then push 4 entries with paddr 0x1000/0x1010/0x1020/0x1030 and hit=4'b0010 → full_o=1, push_ready_o=0. The fifth push is refused.
- Commit 2 with drain_ready_i=1 → drain_way_o=1 for the heads at 0x1000 then 0x1010 on consecutive cycles. head=2; the entries at 0x1020 and 0x1030 are not drained.
- Entry paddr 0x2040 with hit=0, committed → miss_valid_o=1, miss_paddr_o=0x2040, held 3 cycles until miss_ready_i. Then snoop taddr[11:4]=0x04, twe=4'b1000, t.p=0x2, t.wp=1 → hit=4'b1000, drain with way 3.
- Push concurrent with snoop to the same set clearing hit[1] → stored hit[1]=0.
- Committed head with hit=4'b0001 and a same-cycle snoop to its set → drain_valid_o=0 that cycle; drain proceeds the next cycle with the updated hit.
- Two committed and two uncommitted entries, then flush_i → tail=commit_ptr and entry_valid_o shows 2 valid entries. A push in that cycle is not stored.
